// File: rtl/cat_trap_engine.sv
`default_nettype none
// ============================================================================
// Module   : cat_trap_engine
// Purpose  : Cat Trap game core. It holds the board, cursor and cat and runs
//            the game FSM. It also renders the board to the VGA pixel stream.
// Revision : 1.0 - initial release
// ============================================================================
module cat_trap_engine #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int CELL  = 50,
  parameter int PITCH = 60,
  parameter int X0    = 222,
  parameter int Y0    = 35
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  output logic [11:0] rgb,
  output logic [2:0]  game_state,
  output logic        won,
  output logic [7:0]  moves
);

  localparam int c_RW = $clog2(ROWS);
  localparam int c_CW = $clog2(COLS);

  localparam logic [c_RW-1:0] c_ROW_MAX = c_RW'(ROWS - 1);
  localparam logic [c_CW-1:0] c_COL_MAX = c_CW'(COLS - 1);
  localparam logic [c_RW-1:0] c_ROW_MID = c_RW'(ROWS >> 1);
  localparam logic [c_CW-1:0] c_COL_MID = c_CW'(COLS >> 1);

  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_BLOCK = 2'd1;
  localparam logic [1:0] c_CAT   = 2'd2;

  localparam logic [11:0] c_RGB_OFF    = 12'h000;
  localparam logic [11:0] c_RGB_CAT    = 12'hF80;
  localparam logic [11:0] c_RGB_BLOCK  = 12'h888;
  localparam logic [11:0] c_RGB_CURSOR = 12'h0FF;
  localparam logic [11:0] c_RGB_EMPTY  = 12'hFFF;
  localparam logic [11:0] c_RGB_BG     = 12'h222;
  localparam logic [11:0] c_RGB_WIN    = 12'h0F0;
  localparam logic [11:0] c_RGB_LOSE   = 12'hF00;

  typedef enum logic [1:0] {
    S_START   = 2'd0,
    S_PLAY    = 2'd1,
    S_CATMOVE = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ROWS-1:0][COLS-1:0][1:0] r_board;
  logic [c_RW-1:0] r_cur_r, r_cat_r;
  logic [c_CW-1:0] r_cur_c, r_cat_c;
  logic [7:0]      r_moves;
  logic            r_won;
  logic [11:0]     r_rgb;

  logic [c_RW-1:0] w_cur_r_next, w_dn_r, w_up_r, w_dst_r;
  logic [c_CW-1:0] w_cur_c_next, w_rt_c, w_lf_c, w_dst_c;
  logic            w_clear, w_place, w_cat_go, w_dst_ok, w_dst_border;
  logic [1:0]      w_cell_cur;

  // Neighbour indices; the cat is interior whenever these are used.
  assign w_dn_r     = r_cat_r + 1'b1;
  assign w_up_r     = r_cat_r - 1'b1;
  assign w_rt_c     = r_cat_c + 1'b1;
  assign w_lf_c     = r_cat_c - 1'b1;
  assign w_cell_cur = r_board[r_cur_r][r_cur_c];

  always_comb begin
    w_dst_r  = r_cat_r;
    w_dst_c  = r_cat_c;
    w_dst_ok = 1'b1;
    if (r_board[w_dn_r][r_cat_c] == c_EMPTY)      w_dst_r = w_dn_r;
    else if (r_board[w_up_r][r_cat_c] == c_EMPTY) w_dst_r = w_up_r;
    else if (r_board[r_cat_r][w_rt_c] == c_EMPTY) w_dst_c = w_rt_c;
    else if (r_board[r_cat_r][w_lf_c] == c_EMPTY) w_dst_c = w_lf_c;
    else                                          w_dst_ok = 1'b0;
  end

  assign w_dst_border = (w_dst_r == '0) || (w_dst_r == c_ROW_MAX) ||
                        (w_dst_c == '0) || (w_dst_c == c_COL_MAX);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_START;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_place      = 1'b0;
    w_cat_go     = 1'b0;
    w_cur_r_next = r_cur_r;
    w_cur_c_next = r_cur_c;
    case (r_state)
      S_START: begin
        if (btn_center) begin
          w_clear      = 1'b1;
          w_state_next = S_PLAY;
        end
      end
      S_PLAY: begin
        if (btn_center) begin
          if (w_cell_cur == c_EMPTY) begin
            w_place      = 1'b1;
            w_state_next = S_CATMOVE;
          end
        end else if (btn_up) begin
          w_cur_r_next = (r_cur_r == '0) ? c_ROW_MAX : r_cur_r - 1'b1;
        end else if (btn_down) begin
          w_cur_r_next = (r_cur_r == c_ROW_MAX) ? '0 : r_cur_r + 1'b1;
        end else if (btn_left) begin
          w_cur_c_next = (r_cur_c == '0) ? c_COL_MAX : r_cur_c - 1'b1;
        end else if (btn_right) begin
          w_cur_c_next = (r_cur_c == c_COL_MAX) ? '0 : r_cur_c + 1'b1;
        end
      end
      S_CATMOVE: begin
        if (!w_dst_ok) begin
          w_state_next = S_END;
        end else begin
          w_cat_go     = 1'b1;
          w_state_next = w_dst_border ? S_END : S_PLAY;
        end
      end
      S_END: begin
        if (btn_center) w_state_next = S_START;
      end
      default: w_state_next = S_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      r_board                       <= '0;
      r_board[c_ROW_MID][c_COL_MID] <= c_CAT;
      r_cat_r                       <= c_ROW_MID;
      r_cat_c                       <= c_COL_MID;
      r_cur_r                       <= '0;
      r_cur_c                       <= '0;
      r_moves                       <= '0;
      r_won                         <= 1'b0;
    end else begin
      r_cur_r <= w_cur_r_next;
      r_cur_c <= w_cur_c_next;
      if (w_place) begin
        r_board[r_cur_r][r_cur_c] <= c_BLOCK;
        if (r_moves != 8'hFF) r_moves <= r_moves + 8'd1;
      end
      if (w_cat_go) begin
        r_board[r_cat_r][r_cat_c] <= c_EMPTY;
        r_board[w_dst_r][w_dst_c] <= c_CAT;
        r_cat_r                   <= w_dst_r;
        r_cat_c                   <= w_dst_c;
      end
      if (r_state == S_CATMOVE) r_won <= !w_dst_ok;
    end
  end

  // Per-cell window comparators; windows never overlap, so OR-ing the
  // indices of the active window yields the hit index.
  logic [COLS-1:0] w_in_col;
  logic [ROWS-1:0] w_in_row;
  logic [c_CW-1:0] w_col_acc [COLS+1];
  logic [c_RW-1:0] w_row_acc [ROWS+1];

  assign w_col_acc[0] = '0;
  assign w_row_acc[0] = '0;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam logic [9:0] c_LO = 10'(X0 + c * PITCH);
    localparam logic [9:0] c_HI = 10'(X0 + c * PITCH + CELL);
    assign w_in_col[c]    = (hCount >= c_LO) && (hCount <= c_HI);
    assign w_col_acc[c+1] = w_col_acc[c] | (w_in_col[c] ? c_CW'(c) : '0);
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam logic [9:0] c_LO = 10'(Y0 + r * PITCH);
    localparam logic [9:0] c_HI = 10'(Y0 + r * PITCH + CELL);
    assign w_in_row[r]    = (vCount >= c_LO) && (vCount <= c_HI);
    assign w_row_acc[r+1] = w_row_acc[r] | (w_in_row[r] ? c_RW'(r) : '0);
  end

  logic [c_RW-1:0] w_pix_r;
  logic [c_CW-1:0] w_pix_c;
  logic [1:0]      w_pix_code;
  logic            w_in_cell, w_cursor_hit;
  logic [11:0]     w_rgb_next;

  assign w_pix_r      = w_row_acc[ROWS];
  assign w_pix_c      = w_col_acc[COLS];
  assign w_in_cell    = (|w_in_col) && (|w_in_row);
  assign w_pix_code   = r_board[w_pix_r][w_pix_c];
  assign w_cursor_hit = (r_state == S_PLAY) && (w_pix_r == r_cur_r) && (w_pix_c == r_cur_c);

  always_comb begin
    w_rgb_next = c_RGB_OFF;
    if (!bright) begin
      w_rgb_next = c_RGB_OFF;
    end else if (w_in_cell) begin
      if (w_pix_code == c_CAT)        w_rgb_next = c_RGB_CAT;
      else if (w_pix_code == c_BLOCK) w_rgb_next = c_RGB_BLOCK;
      else if (w_cursor_hit)          w_rgb_next = c_RGB_CURSOR;
      else                            w_rgb_next = c_RGB_EMPTY;
    end else if (r_state == S_END) begin
      w_rgb_next = r_won ? c_RGB_WIN : c_RGB_LOSE;
    end else begin
      w_rgb_next = c_RGB_BG;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_rgb <= c_RGB_OFF;
    else       r_rgb <= w_rgb_next;
  end

  // CATMOVE is internal and reports as PLAY.
  always_comb begin
    game_state = 3'b001;
    case (r_state)
      S_START:   game_state = 3'b001;
      S_PLAY:    game_state = 3'b010;
      S_CATMOVE: game_state = 3'b010;
      S_END:     game_state = 3'b100;
      default:   game_state = 3'b001;
    endcase
  end

  assign rgb   = r_rgb;
  assign won   = r_won;
  assign moves = r_moves;

endmodule
`default_nettype wire
